// File: rtl/controlo_barreira.sv
// Parking-gate sequencer: timed barrier motion (open/hold/close) with obstacle
// reopen and lot occupancy tracking.
module controlo_barreira #(
  parameter int T_MOVER   = 50,
  parameter int T_ABERTA  = 500,
  parameter int N_LUGARES = 8,
  parameter int W         = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         Sensor_Entrada,
  input  logic         Pedido,
  input  logic         Sensor_Passagem,
  input  logic         Saida,
  output logic         Barreira,
  output logic         Motor_Abrir,
  output logic         Motor_Fechar,
  output logic [W-1:0] Ocupados,
  output logic         Cheio
);

  localparam int TMAX = (T_ABERTA > T_MOVER) ? T_ABERTA : T_MOVER;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] T_MOVER_C  = TW'(T_MOVER - 1);
  localparam logic [TW-1:0] T_ABERTA_C = TW'(T_ABERTA - 1);
  localparam logic [TW-1:0] ONE_T      = TW'(1);
  localparam logic [TW-1:0] ZERO_T     = TW'(0);
  localparam logic [W-1:0]  N_C        = W'(N_LUGARES);
  localparam logic [W-1:0]  ONE_O      = W'(1);
  localparam logic [W-1:0]  ZERO_O     = W'(0);

  typedef enum logic [1:0] {
    FECHADA  = 2'd0,
    A_ABRIR  = 2'd1,
    ABERTA   = 2'd2,
    A_FECHAR = 2'd3
  } estado_t;

  estado_t       state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [W-1:0]  ocup_q, ocup_d;
  logic          prev_q;
  logic          barreira_q, barreira_d;
  logic          abrir_q, abrir_d;
  logic          fechar_q, fechar_d;
  logic          passagem_s;
  logic          entrou_s;
  logic          cheio_s;

  // A car has cleared the barrier when the passage sensor falls.
  assign passagem_s = prev_q & ~Sensor_Passagem;
  assign cheio_s    = (ocup_q == N_C);

  // State register, timer, passage-edge sampler, occupancy and Moore outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= FECHADA;
      timer_q    <= ZERO_T;
      prev_q     <= 1'b0;
      ocup_q     <= ZERO_O;
      barreira_q <= 1'b0;
      abrir_q    <= 1'b0;
      fechar_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      prev_q     <= Sensor_Passagem;
      ocup_q     <= ocup_d;
      barreira_q <= barreira_d;
      abrir_q    <= abrir_d;
      fechar_q   <= fechar_d;
    end
  end

  // Next-state and timer logic.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    entrou_s = 1'b0;
    case (state_q)
      FECHADA: begin
        if (Pedido && Sensor_Entrada && !cheio_s) begin
          state_d = A_ABRIR;
          timer_d = T_MOVER_C;
        end else begin
          state_d = FECHADA;
        end
      end
      A_ABRIR: begin
        if (timer_q == ZERO_T) begin
          state_d = ABERTA;
          timer_d = T_ABERTA_C;
        end else begin
          timer_d = timer_q - ONE_T;
        end
      end
      ABERTA: begin
        if (passagem_s) begin
          entrou_s = 1'b1;
          state_d  = A_FECHAR;
          timer_d  = T_MOVER_C;
        end else if (Sensor_Passagem) begin
          timer_d = timer_q;
        end else if (timer_q == ZERO_T) begin
          state_d = A_FECHAR;
          timer_d = T_MOVER_C;
        end else begin
          timer_d = timer_q - ONE_T;
        end
      end
      A_FECHAR: begin
        // An obstacle always forces a full reopen, even on the expiry cycle.
        if (Sensor_Passagem) begin
          state_d = A_ABRIR;
          timer_d = T_MOVER_C;
        end else if (timer_q == ZERO_T) begin
          state_d = FECHADA;
          timer_d = ZERO_T;
        end else begin
          timer_d = timer_q - ONE_T;
        end
      end
      default: begin
        state_d = FECHADA;
        timer_d = ZERO_T;
      end
    endcase
  end

  // Occupancy update; an entry and an exit in the same cycle cancel out.
  always_comb begin
    ocup_d = ocup_q;
    if (entrou_s && !Saida) begin
      if (ocup_q < N_C) begin
        ocup_d = ocup_q + ONE_O;
      end else begin
        ocup_d = ocup_q;
      end
    end else if (Saida && !entrou_s) begin
      if (ocup_q != ZERO_O) begin
        ocup_d = ocup_q - ONE_O;
      end else begin
        ocup_d = ocup_q;
      end
    end else begin
      ocup_d = ocup_q;
    end
  end

  // Output decode from the next state so outputs switch on the transition edge.
  always_comb begin
    barreira_d = (state_d != FECHADA);
    abrir_d    = (state_d == A_ABRIR);
    fechar_d   = (state_d == A_FECHAR);
  end

  assign Barreira     = barreira_q;
  assign Motor_Abrir  = abrir_q;
  assign Motor_Fechar = fechar_q;
  assign Ocupados     = ocup_q;
  assign Cheio        = cheio_s;

endmodule

// File: tb/tb_controlo_barreira.sv
// Table-driven bench for controlo_barreira with a scoreboard queue of expected outputs.
module tb_controlo_barreira;

  logic       CLK;
  logic       RST;
  logic       Sensor_Entrada;
  logic       Pedido;
  logic       Sensor_Passagem;
  logic       Saida;
  logic       Barreira;
  logic       Motor_Abrir;
  logic       Motor_Fechar;
  logic [3:0] Ocupados;
  logic       Cheio;

  int n_checks = 0;
  int n_fail   = 0;
  int row_no   = 0;

  typedef struct {
    logic       ent;
    logic       ped;
    logic       pas;
    logic       sai;
    logic       bar;
    logic       ab;
    logic       fe;
    logic [3:0] oc;
    logic       ch;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  controlo_barreira #(
    .T_MOVER  (4),
    .T_ABERTA (10),
    .N_LUGARES(2),
    .W        (4)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .Sensor_Entrada (Sensor_Entrada),
    .Pedido         (Pedido),
    .Sensor_Passagem(Sensor_Passagem),
    .Saida          (Saida),
    .Barreira       (Barreira),
    .Motor_Abrir    (Motor_Abrir),
    .Motor_Fechar   (Motor_Fechar),
    .Ocupados       (Ocupados),
    .Cheio          (Cheio)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic e, input logic p, input logic s, input logic x,
                     input logic b, input logic a, input logic f,
                     input logic [3:0] o, input logic c, input int n);
    vec_t v;
    v.ent = e; v.ped = p; v.pas = s; v.sai = x;
    v.bar = b; v.ab = a; v.fe = f; v.oc = o; v.ch = c;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Entry with a car passing: sensor high 3 cycles in ABERTA, then falls.
  task automatic seq_entry(input logic [3:0] o, input logic c1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, o, 1'b0, 1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, o, 1'b0, 3);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, o, 1'b0, 1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, o, 1'b0, 3);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, o + 4'd1, c1, 4);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o + 4'd1, c1, 1);
  endtask

  task automatic apply_row(input vec_t v);
    vec_t e;
    @(negedge CLK);
    Sensor_Entrada  = v.ent;
    Pedido          = v.ped;
    Sensor_Passagem = v.pas;
    Saida           = v.sai;
    exp_q.push_back(v);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if ({Barreira, Motor_Abrir, Motor_Fechar, Ocupados, Cheio} !==
        {e.bar, e.ab, e.fe, e.oc, e.ch}) begin
      n_fail++;
      $display("FAIL row%0d bar/ab/fe/oc/ch: got %b/%b/%b/%0d/%b expected %b/%b/%b/%0d/%b",
               row_no, Barreira, Motor_Abrir, Motor_Fechar, Ocupados, Cheio,
               e.bar, e.ab, e.fe, e.oc, e.ch);
    end
    row_no++;
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) apply_row(vecs[i]);
    vecs.delete();
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if ({Barreira, Motor_Abrir, Motor_Fechar, Ocupados, Cheio} !== 8'd0) begin
      n_fail++;
      $display("FAIL %s bar/ab/fe/oc/ch: got %b/%b/%b/%0d/%b expected all zero",
               name, Barreira, Motor_Abrir, Motor_Fechar, Ocupados, Cheio);
    end
  endtask

  initial begin
    RST             = 1'b1;
    Sensor_Entrada  = 1'b0;
    Pedido          = 1'b0;
    Sensor_Passagem = 1'b0;
    Saida           = 1'b0;
    #1;
    check_zero("reset_state");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Entry with passage: occupancy 0 -> 1.
    seq_entry(4'd0, 1'b0);
    // Timeout: ABERTA lasts 10 cycles, no count change.
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 3);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 10);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 4);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1);
    // Pedido without a car waiting: no motion.
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 2);
    // Obstacle on the 2nd cycle of A_FECHAR: full reopen.
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 3);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 10);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 2);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 3);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 10);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 4);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1);
    // Passage and Saida in the same cycle: occupancy stays 1.
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 3);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 3);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1);
    // Second car fills the lot; requests are then refused.
    seq_entry(4'd1, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 2);
    // Exits: 2 -> 1 -> 0, then no wrap below zero.
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1);
    // Refill to 1 and stop two cycles into A_ABRIR.
    seq_entry(4'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1);
    run_table();

    // Asynchronous reset between edges, mid-A_ABRIR.
    #2;
    RST = 1'b1;
    #1;
    check_zero("async_reset_immediate");
    @(posedge CLK);
    #1;
    check_zero("reset_held_over_edge");
    @(negedge CLK);
    RST = 1'b0;

    // Full sequence again after reset release.
    seq_entry(4'd0, 1'b0);
    run_table();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
